// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_DELIVER = 2'd2,
        ST_ERROR   = 2'd3
    } fetch_state_e;

    localparam logic [31:0] INSTR_BYTES      = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int          DEFAULT_TIMEOUT  = 16;

endpackage

// File: rtl/fetch_pc_next.sv
// Next-PC adder: sequential or branch-redirected target of the presented instruction.
module fetch_pc_next
    import fetch_ctrl_pkg::*;
(
    input  logic [31:0] ins_pc_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_offset_i,
    output logic [31:0] pc_next_o,
    output logic        misalign_o
);

    logic [31:0] offset_sel;

    assign offset_sel = branch_taken_i ? branch_offset_i : 32'd0;
    // Wraps modulo 2^32 by construction of the 32-bit sum.
    assign pc_next_o  = ins_pc_i + INSTR_BYTES + offset_sel;
    assign misalign_o = |pc_next_o[1:0];

endmodule

// File: rtl/fetch_ctrl.sv
// Single-outstanding instruction fetch controller with timeout and redirect checking.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          TIMEOUT  = DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_offset,
    output logic [31:0] ins,
    output logic        ins_valid,
    output logic [31:0] ins_pc,
    output logic        fetch_err
);

    localparam int                WAIT_W    = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    fetch_state_e      state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic              imem_req_q, imem_req_d;
    logic [31:0]       imem_addr_q, imem_addr_d;
    logic [31:0]       ins_q, ins_d;
    logic [31:0]       ins_pc_q, ins_pc_d;
    logic              ins_valid_q, ins_valid_d;
    logic              fetch_err_q, fetch_err_d;
    logic [WAIT_W-1:0] wait_q, wait_d;

    logic [31:0] pc_next;
    logic        pc_misalign;
    logic        ack_hit;
    logic        timeout_hit;
    logic        consume;

    fetch_pc_next u_pc_next (
        .ins_pc_i        (ins_pc_q),
        .branch_taken_i  (branch_taken),
        .branch_offset_i (branch_offset),
        .pc_next_o       (pc_next),
        .misalign_o      (pc_misalign)
    );

    // An ack arriving on the last allowed wait cycle wins over the timeout.
    assign ack_hit     = (state_q == ST_REQ) && imem_ack;
    assign timeout_hit = (state_q == ST_REQ) && !imem_ack && (wait_q == WAIT_LAST);
    assign consume     = (state_q == ST_DELIVER) && !stall;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            pc_q        <= RESET_PC;
            imem_req_q  <= 1'b0;
            imem_addr_q <= RESET_PC;
            ins_q       <= 32'd0;
            ins_pc_q    <= 32'd0;
            ins_valid_q <= 1'b0;
            fetch_err_q <= 1'b0;
            wait_q      <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            imem_req_q  <= imem_req_d;
            imem_addr_q <= imem_addr_d;
            ins_q       <= ins_d;
            ins_pc_q    <= ins_pc_d;
            ins_valid_q <= ins_valid_d;
            fetch_err_q <= fetch_err_d;
            wait_q      <= wait_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    state_d = ST_REQ;
            ST_REQ: begin
                if (ack_hit)          state_d = ST_DELIVER;
                else if (timeout_hit) state_d = ST_ERROR;
            end
            ST_DELIVER: begin
                if (consume) state_d = pc_misalign ? ST_ERROR : ST_REQ;
            end
            ST_ERROR:   state_d = ST_ERROR;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pc_d        = pc_q;
        imem_req_d  = imem_req_q;
        imem_addr_d = imem_addr_q;
        ins_d       = ins_q;
        ins_pc_d    = ins_pc_q;
        ins_valid_d = ins_valid_q;
        fetch_err_d = fetch_err_q;
        wait_d      = wait_q;
        case (state_q)
            ST_IDLE: begin
                imem_req_d  = 1'b1;
                imem_addr_d = pc_q;
                wait_d      = '0;
            end
            ST_REQ: begin
                if (ack_hit) begin
                    imem_req_d  = 1'b0;
                    ins_d       = imem_data;
                    ins_pc_d    = pc_q;
                    ins_valid_d = 1'b1;
                end else if (timeout_hit) begin
                    imem_req_d  = 1'b0;
                    fetch_err_d = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ST_DELIVER: begin
                if (consume) begin
                    ins_valid_d = 1'b0;
                    if (pc_misalign) begin
                        fetch_err_d = 1'b1;
                    end else begin
                        pc_d        = pc_next;
                        imem_req_d  = 1'b1;
                        imem_addr_d = pc_next;
                        wait_d      = '0;
                    end
                end
            end
            default: begin
                imem_req_d  = 1'b0;
                ins_valid_d = 1'b0;
                fetch_err_d = 1'b1;
            end
        endcase
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = imem_addr_q;
    assign ins       = ins_q;
    assign ins_pc    = ins_pc_q;
    assign ins_valid = ins_valid_q;
    assign fetch_err = fetch_err_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed and randomized bench for fetch_ctrl against a rule-level fetch model.
module tb_fetch_ctrl;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          TMO    = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_data = 32'd0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_offset = 32'd0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] ins;
    logic        ins_valid;
    logic [31:0] ins_pc;
    logic        fetch_err;

    int checks = 0;
    int errors = 0;

    fetch_ctrl #(
        .RESET_PC (RST_PC),
        .TIMEOUT  (TMO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_data     (imem_data),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .ins           (ins),
        .ins_valid     (ins_valid),
        .ins_pc        (ins_pc),
        .fetch_err     (fetch_err)
    );

    always #5 clk = ~clk;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
        end
    endtask

    // Rule-level model: what the fetch unit must be showing after the next edge.
    logic        m_en = 1'b0;
    logic        m_err, m_req, m_valid, m_boot;
    logic [31:0] m_addr, m_ins, m_ins_pc;
    int          m_wait;
    longint      m_tgt;

    initial begin : compare_proc
        forever begin
            @(negedge clk);
            if (m_en) begin
                chk1("m_imem_req", imem_req, m_req);
                chk1("m_ins_valid", ins_valid, m_valid);
                chk1("m_fetch_err", fetch_err, m_err);
                if (m_req) chk32("m_imem_addr", imem_addr, m_addr);
                if (m_valid) begin
                    chk32("m_ins", ins, m_ins);
                    chk32("m_ins_pc", ins_pc, m_ins_pc);
                end
            end
            // Advance the model with the inputs the coming edge will sample.
            if (!reset) begin
                m_en = 1'b1; m_err = 1'b0; m_req = 1'b0; m_valid = 1'b0; m_boot = 1'b1;
                m_addr = RST_PC; m_ins = 32'd0; m_ins_pc = 32'd0; m_wait = 0;
            end else if (!m_en || m_err) begin
                m_en = m_en;
            end else if (m_boot) begin
                m_boot = 1'b0; m_req = 1'b1; m_addr = RST_PC; m_wait = 0;
            end else if (m_req) begin
                if (imem_ack) begin
                    m_ins = imem_data; m_ins_pc = m_addr; m_valid = 1'b1; m_req = 1'b0;
                end else begin
                    m_wait = m_wait + 1;
                    if (m_wait >= TMO) begin
                        m_err = 1'b1; m_req = 1'b0;
                    end
                end
            end else if (m_valid && !stall) begin
                m_tgt = (longint'(m_ins_pc) + 64'd4 + (branch_taken ? longint'(branch_offset) : 64'd0))
                        % 64'h1_0000_0000;
                m_valid = 1'b0;
                if ((m_tgt % 4) != 0) begin
                    m_err = 1'b1;
                end else begin
                    m_req = 1'b1; m_addr = m_tgt[31:0]; m_wait = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0; imem_ack = 1'b0; stall = 1'b0; branch_taken = 1'b0;
        repeat (n) tick();
        reset = 1'b1;
    endtask

    task automatic wait_req(input logic [31:0] exp_addr, input string name);
        int n = 0;
        while (imem_req !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk1({name, "_req"}, imem_req, 1'b1);
        chk32({name, "_addr"}, imem_addr, exp_addr);
    endtask

    task automatic fetch_one(input logic [31:0] exp_addr, input int delay, input int stall_n,
                             input logic bt, input logic [31:0] off, input string name);
        logic [31:0] data;
        data = $urandom;
        wait_req(exp_addr, name);
        imem_ack = 1'b0;
        for (int i = 0; i < delay; i++) begin
            stall = ($urandom_range(0, 1) == 1);
            tick();
            chk1({name, "_hold_req"}, imem_req, 1'b1);
            chk32({name, "_hold_addr"}, imem_addr, exp_addr);
        end
        imem_ack = 1'b1; imem_data = data;
        tick();
        imem_ack = 1'b0; imem_data = $urandom;
        chk1({name, "_valid"}, ins_valid, 1'b1);
        chk32({name, "_ins"}, ins, data);
        chk32({name, "_ins_pc"}, ins_pc, exp_addr);
        chk1({name, "_noreq"}, imem_req, 1'b0);
        // Branch inputs are garbage while stalled and must not matter.
        stall = 1'b1; branch_taken = 1'b1; branch_offset = 32'h3;
        for (int i = 0; i < stall_n; i++) begin
            tick();
            chk1({name, "_stall_valid"}, ins_valid, 1'b1);
            chk32({name, "_stall_ins"}, ins, data);
            chk32({name, "_stall_pc"}, ins_pc, exp_addr);
            chk1({name, "_stall_noreq"}, imem_req, 1'b0);
        end
        stall = 1'b0; branch_taken = bt; branch_offset = off;
        tick();
        branch_taken = 1'b1; branch_offset = $urandom;
        chk1({name, "_consumed"}, ins_valid, 1'b0);
        $display("TXN %s addr=%h ins=%h delay=%0d stall=%0d bt=%b off=%h",
                 name, exp_addr, data, delay, stall_n, bt, off);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        do_reset(2);
        chk1("rst_req", imem_req, 1'b0);
        chk32("rst_addr", imem_addr, RST_PC);
        chk1("rst_valid", ins_valid, 1'b0);
        chk1("rst_err", fetch_err, 1'b0);
        chk32("rst_ins", ins, 32'd0);
        chk32("rst_ins_pc", ins_pc, 32'd0);
        tick();
        chk1("first_req", imem_req, 1'b1);
        chk32("first_addr", imem_addr, RST_PC);

        // Back-to-back sequential fetches at full rate, then delayed ack, stall and branch.
        fetch_one(32'h0, 0, 0, 1'b0, 32'h0, "seq0");
        chk1("rate_req", imem_req, 1'b1);
        chk32("rate_addr", imem_addr, 32'h4);
        fetch_one(32'h4, 0, 0, 1'b0, 32'h0, "seq4");
        fetch_one(32'h8, 5, 4, 1'b1, 32'h10, "br8");
        fetch_one(32'h1C, TMO - 1, 0, 1'b0, 32'h0, "late_ack");
        chk1("late_ack_err", fetch_err, 1'b0);

        wait_req(32'h20, "tmo");
        for (int i = 1; i < TMO; i++) begin
            tick();
            chk1("tmo_wait_req", imem_req, 1'b1);
            chk1("tmo_wait_err", fetch_err, 1'b0);
        end
        tick();
        chk1("tmo_err", fetch_err, 1'b1);
        chk1("tmo_req", imem_req, 1'b0);
        imem_ack = 1'b1;
        repeat (3) tick();
        imem_ack = 1'b0;
        chk1("tmo_sticky", fetch_err, 1'b1);
        chk1("tmo_novalid", ins_valid, 1'b0);
        do_reset(1);
        chk1("tmo_rst_err", fetch_err, 1'b0);
        wait_req(RST_PC, "restart");

        fetch_one(RST_PC, 0, 0, 1'b1, 32'h2, "mis");
        chk1("mis_err", fetch_err, 1'b1);
        chk1("mis_req", imem_req, 1'b0);
        repeat (3) tick();
        chk1("mis_still_noreq", imem_req, 1'b0);

        do_reset(1);
        fetch_one(RST_PC, 0, 0, 1'b1, 32'hFFFF_FFF8, "to_top");
        fetch_one(32'hFFFF_FFFC, 0, 1, 1'b0, 32'h0, "top");
        wait_req(32'h0, "wrap");
        chk1("wrap_err", fetch_err, 1'b0);

        // Reset during REQ with a late ack.
        reset = 1'b0;
        tick();
        chk1("midrst_req", imem_req, 1'b0);
        reset = 1'b1; imem_ack = 1'b1; imem_data = 32'hDEAD_BEEF;
        tick();
        imem_ack = 1'b0;
        chk1("midrst_novalid", ins_valid, 1'b0);
        chk32("midrst_addr", imem_addr, RST_PC);
        tick();
        chk1("midrst_novalid2", ins_valid, 1'b0);
        fetch_one(RST_PC, 1, 0, 1'b0, 32'h0, "after_rst");

        // Randomized traffic, with periodic ack droughts to provoke timeouts.
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (fetch_err) reset = ($urandom_range(0, 3) == 0);
            else           reset = ($urandom_range(0, 399) != 0);
            imem_ack  = ((i % 300) > 270) ? 1'b0 : ($urandom_range(0, 2) == 0);
            imem_data = $urandom;
            stall = ($urandom_range(0, 2) == 0);
            branch_taken = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 39) == 0)
                branch_offset = 32'($urandom_range(1, 3));
            else
                branch_offset = 32'(($urandom_range(0, 255) - 128) * 4);
        end
        reset = 1'b1; imem_ack = 1'b0; stall = 1'b0;
        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
